// File: rtl/move_order_ctrl_pkg.sv
// Shared types and helpers for the move-ordering sequencer.
package move_order_pkg;

    localparam int STAT_BITS = 16;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FILL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    function automatic int COUNT_BITS(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/move_order_ctrl_if.sv
// Generator-side beat channel and search-side move channel of the sequencer.
interface move_order_ctrl_if #(
    parameter int KEY_BITS   = 8,
    parameter int VALUE_BITS = 15
);
    logic [VALUE_BITS-1:0] gen_value_in;
    logic [KEY_BITS-1:0]   gen_key_in;
    logic                  gen_valid_in;
    logic                  gen_last_in;
    logic                  gen_none_in;
    logic                  gen_ready_out;
    logic                  move_valid_out;
    logic [VALUE_BITS-1:0] move_value_out;
    logic [KEY_BITS-1:0]   move_key_out;
    logic                  move_last_out;
    logic                  move_ready_in;

    modport slave (
        input  gen_value_in, gen_key_in, gen_valid_in, gen_last_in, gen_none_in, move_ready_in,
        output gen_ready_out, move_valid_out, move_value_out, move_key_out, move_last_out
    );

    modport master (
        output gen_value_in, gen_key_in, gen_valid_in, gen_last_in, gen_none_in, move_ready_in,
        input  gen_ready_out, move_valid_out, move_value_out, move_key_out, move_last_out
    );
endinterface

// File: rtl/move_order_ctrl_stats.sv
// Saturating insert/pop/stall counters; built only with MOVE_ORDER_STATS_EN.
module move_order_stats
    import move_order_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 clear_in,
    input  logic                 insert_in,
    input  logic                 pop_in,
    input  logic                 stall_in,
    output logic [STAT_BITS-1:0] stat_inserts_out,
    output logic [STAT_BITS-1:0] stat_pops_out,
    output logic [STAT_BITS-1:0] stat_stall_out
);
    logic [2:0]                inc;
    logic [2:0][STAT_BITS-1:0] cnt_w;

    assign inc = {stall_in, pop_in, insert_in};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [STAT_BITS-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear_in)
                    cnt_d = '0;
                else if (inc[gi] && !(&cnt_q))
                    cnt_d = cnt_q + 1'b1;
            end

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in)
                    cnt_q <= '0;
                else
                    cnt_q <= cnt_d;
            end

            assign cnt_w[gi] = cnt_q;
        end
    endgenerate

    assign stat_inserts_out = cnt_w[0];
    assign stat_pops_out    = cnt_w[1];
    assign stat_stall_out   = cnt_w[2];
endmodule

// File: rtl/move_order_ctrl.sv
// Sequencer that clears the move sorter, fills it from the generator and drains it to search.
// Optional statistics counters are enabled by defining MOVE_ORDER_STATS_EN.
module move_order_ctrl
    import move_order_pkg::*;
#(
    parameter  int MAX_LEN    = 32,
    parameter  int KEY_BITS   = 8,
    parameter  int VALUE_BITS = 15,
    localparam int CNT_W      = COUNT_BITS(MAX_LEN)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    move_order_ctrl_if.slave      bus,
    output logic                  srt_rst_out,
    output logic                  srt_valid_out,
    output logic [VALUE_BITS-1:0] srt_value_out,
    output logic [KEY_BITS-1:0]   srt_key_out,
    output logic                  srt_dequeue_out,
    input  logic [VALUE_BITS-1:0] srt_head_value_in,
    input  logic [KEY_BITS-1:0]   srt_head_key_in,
    output logic                  done_out,
    output logic                  busy_out,
    output logic [CNT_W-1:0]      count_out,
    output logic [STAT_BITS-1:0]  stat_inserts_out,
    output logic [STAT_BITS-1:0]  stat_pops_out,
    output logic [STAT_BITS-1:0]  stat_stall_out
);
    localparam logic [1:0] CLEAR_S = ST_CLEAR;
    localparam logic [1:0] IDLE_S  = ST_IDLE;
    localparam logic [1:0] FILL_S  = ST_FILL;
    localparam logic [1:0] DRAIN_S = ST_DRAIN;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic             refill_q, refill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             in_fill, in_drain, insert, dequeue;

    assign in_fill  = (state_q == FILL_S);
    assign in_drain = (state_q == DRAIN_S);

    // Abort masks both handshakes so neither side sees a transfer that did not happen.
    assign bus.gen_ready_out  = in_fill && !abort_in && (count_q < FULL);
    assign insert             = bus.gen_valid_in && bus.gen_ready_out;
    assign bus.move_valid_out = in_drain && !abort_in && (count_q != '0);
    assign dequeue            = bus.move_valid_out && bus.move_ready_in;

    assign bus.move_value_out = srt_head_value_in;
    assign bus.move_key_out   = srt_head_key_in;
    assign bus.move_last_out  = in_drain && (count_q == ONE);

    assign srt_rst_out     = (state_q == CLEAR_S);
    assign srt_valid_out   = insert;
    assign srt_value_out   = bus.gen_value_in;
    assign srt_key_out     = bus.gen_key_in;
    assign srt_dequeue_out = dequeue;

    assign done_out  = done_q;
    assign busy_out  = (state_q != IDLE_S);
    assign count_out = count_q;

    always_comb begin
        state_d  = state_q;
        refill_d = refill_q;
        count_d  = count_q;
        done_d   = 1'b0;
        case (state_q)
            CLEAR_S: begin
                count_d  = '0;
                refill_d = 1'b0;
                state_d  = refill_q ? FILL_S : IDLE_S;
            end
            IDLE_S: begin
                if (start_in) begin
                    state_d  = CLEAR_S;
                    refill_d = 1'b1;
                end
            end
            FILL_S: begin
                if (abort_in) begin
                    state_d  = CLEAR_S;
                    refill_d = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    if (insert)
                        count_d = count_q + ONE;
                    if (insert && bus.gen_last_in)
                        state_d = DRAIN_S;
                    else if (bus.gen_none_in && (count_q == '0))
                        state_d = DRAIN_S;
                end
            end
            default: begin
                if (abort_in) begin
                    state_d  = CLEAR_S;
                    refill_d = 1'b0;
                    done_d   = 1'b1;
                end else if (count_q == '0) begin
                    state_d = IDLE_S;
                end else if (dequeue) begin
                    count_d = count_q - ONE;
                end
            end
        endcase
        // An empty DRAIN cycle is the one that reports completion, then returns to IDLE.
        if ((state_d == DRAIN_S) && (count_d == '0))
            done_d = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= CLEAR_S;
            refill_q <= 1'b0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            refill_q <= refill_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

`ifdef MOVE_ORDER_STATS_EN
    logic stat_clear, stat_stall;

    assign stat_clear = (state_q == IDLE_S) && start_in;
    assign stat_stall = in_fill && bus.gen_valid_in && (count_q == FULL);

    move_order_stats u_stats (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .clear_in         (stat_clear),
        .insert_in        (insert),
        .pop_in           (dequeue),
        .stall_in         (stat_stall),
        .stat_inserts_out (stat_inserts_out),
        .stat_pops_out    (stat_pops_out),
        .stat_stall_out   (stat_stall_out)
    );
`else
    assign stat_inserts_out = '0;
    assign stat_pops_out    = '0;
    assign stat_stall_out   = '0;
`endif
endmodule

// File: doc/move_order_ctrl.md
Name: move_order_ctrl

Overview:
- Sequencer for the move-ordering sorter: clears it, streams scored moves from the move generator into it, then drains moves highest-priority-first to the search engine.
- Sits between the move generator, the sorter and the search FSM, one instance per sorter.
- Guarantees insert and dequeue never coincide, the sorter never overflows, and the sorter's truncated length output is never relied upon.

Parameters:
- MAX_LEN, 32: sorter capacity in entries.
- KEY_BITS, 8: score width.
- VALUE_BITS, 15: encoded move width.

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- start_in  in  1  begin new position; honoured only in IDLE
- abort_in  in  1  cutoff; discard list
- gen_value_in  in  VALUE_BITS  generated move
- gen_key_in  in  KEY_BITS  move score
- gen_valid_in  in  1  generator beat valid
- gen_last_in  in  1  last move of position, qualified by beat handshake
- gen_none_in  in  1  position has zero moves (pulse, no beat)
- gen_ready_out  out  1  controller accepts beat
- srt_rst_out  out  1  synchronous clear to sorter (active high)
- srt_valid_out  out  1  sorter insert strobe
- srt_value_out  out  VALUE_BITS  insert value
- srt_key_out  out  KEY_BITS  insert key
- srt_dequeue_out  out  1  sorter pop strobe
- srt_head_value_in  in  VALUE_BITS  sorter entry 0 value
- srt_head_key_in  in  KEY_BITS  sorter entry 0 key
- move_valid_out  out  1  head move available
- move_value_out  out  VALUE_BITS  head move
- move_key_out  out  KEY_BITS  head score
- move_last_out  out  1  presented move is final one
- move_ready_in  in  1  search accepts move
- done_out  out  1  one-cycle pulse: list exhausted or aborted
- busy_out  out  1  state != IDLE
- count_out  out  $clog2(MAX_LEN+1)  occupancy

Behaviour:
- States: CLEAR, IDLE, FILL, DRAIN. A registered refill flag selects the exit from CLEAR.
- Reset (rst_n_in low):
  - state=CLEAR, refill=0, count=0, srt_rst_out=1, done_out=0.
  - All other registered outputs 0.
  - The first clock after release clears the sorter, then enters IDLE.
- CLEAR: srt_rst_out=1 for exactly one cycle; count<=0. Next state is FILL if refill, else IDLE.
- IDLE: start_in -> CLEAR with refill=1. All other inputs ignored.
- FILL:
  - gen_ready_out = (count < MAX_LEN), combinational.
  - Accepted beat: srt_valid_out=1 the same cycle with value/key passed through; count+1.
  - Accepted beat with gen_last_in -> DRAIN.
  - gen_none_in with count==0 -> DRAIN.
  - When count==MAX_LEN, gen_ready_out=0 and the generator stalls. The generator must not supply more than MAX_LEN moves; a stall at full persists until abort.
- DRAIN:
  - move_valid_out = (count > 0); move_value/key_out = sorter head; move_last_out = (count == 1).
  - Handshake -> srt_dequeue_out=1 the same cycle; count-1.
  - The new head is valid the next cycle, so back-to-back pops run at 1/cycle.
  - count reaching 0 (or 0 on entry) -> done_out pulse on the following cycle -> IDLE.
- Outside FILL: gen_ready_out=0. Outside DRAIN: move_valid_out=0.
- srt_valid_out and srt_dequeue_out are never high together. srt_rst_out is never high with either.
- abort_in has priority over everything in FILL/DRAIN:
  - No insert or dequeue that cycle.
  - -> CLEAR with refill=0; done_out pulses in CLEAR.
  - abort_in in IDLE or CLEAR is ignored.
- start_in outside IDLE is ignored.
- Reset mid-operation aborts immediately; the sorter is cleared via the CLEAR cycle.

Optional Feature:
- Macro MOVE_ORDER_STATS_EN.
- Defined: adds three 16-bit saturating counters, stat_inserts_out, stat_pops_out and stat_stall_out.
  - stat_stall_out counts FILL cycles with gen_valid_in and count==MAX_LEN.
  - All three clear on start_in acceptance and on reset.
- Undefined: the ports remain but are tied 0; no counter logic.

Decomposition:
- Package move_order_pkg: state enum (CLEAR, IDLE, FILL, DRAIN), COUNT_BITS helper function, STAT_BITS=16.
- Sub-module move_order_stats holds the optional counters, instantiated only under the macro.
- The sorter itself is instantiated by the parent, not inside this block.

Test Plan (MAX_LEN=4):
- Reset release -> srt_rst_out=1 for one cycle, then IDLE, busy_out=0, count_out=0.
- start, beats keys 5,9,1 (last on third) -> srt_valid 3 cycles, count 3; drain with move_ready_in held 1 -> 3 consecutive pops, move_last_out on third, done_out next cycle.
- start, 5 beats offered -> 4 accepted, gen_ready_out low with count 4; stat_stall_out increments per stalled cycle (macro on).
- start, gen_none_in -> DRAIN with move_valid_out=0, done_out pulse, IDLE.
- Abort in DRAIN with count 2 and move_ready_in=1 -> no dequeue, CLEAR cycle, done_out pulse, IDLE, count_out=0.
- rst_n_in low mid-FILL -> outputs zero asynchronously, srt_rst_out=1; start_in during DRAIN is ignored.
